rf_scoreboard: RTL and testbench



---
 rtl/rf_scoreboard.sv | 109 ++++++++++
 tb/tb_rf_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port, optional write bypass and a per-register pending-write scoreboard.
// Reads are zero-latency; writes land on the next edge. There is no backpressure: the decode stage stalls on the busy outputs.
module rf_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  read1regsel,
    input  logic [SEL_W-1:0]  read2regsel,
    output logic [DATA_W-1:0] read1data,
    output logic [DATA_W-1:0] read2data,
    output logic              read1busy,
    output logic              read2busy,
    input  logic              write,
    input  logic [SEL_W-1:0]  writeregsel,
    input  logic [DATA_W-1:0] writedata,
    input  logic              issue,
    input  logic [SEL_W-1:0]  issueregsel,
    output logic              err
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;

    logic                w_wr_ok;
    logic                w_iss_ok;
    logic                w_err_set;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [SEL_W-1:0]    w_rsel  [2];
    logic [DATA_W-1:0]   w_rdata [2];
    logic                w_rbusy [2];

    function automatic logic f_in_range(input logic [SEL_W-1:0] s);
        return 32'(s) < 32'(NUM_REGS);
    endfunction

    // Register 0 is excluded in zero-register mode; reads treat it like an unbacked select.
    function automatic logic f_writable(input logic [SEL_W-1:0] s);
        return f_in_range(s) && !((ZERO_REG != 0) && (s == '0));
    endfunction

    assign w_wr_ok  = write && f_writable(writeregsel);
    assign w_iss_ok = issue && f_writable(issueregsel);

    assign w_err_set = (write && !f_in_range(writeregsel))
                     || (issue && !f_in_range(issueregsel))
                     || (w_iss_ok && r_busy[issueregsel]
                         && !(w_wr_ok && (writeregsel == issueregsel)));

    assign w_rsel[0] = read1regsel;
    assign w_rsel[1] = read2regsel;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
            if (f_writable(w_rsel[p])) begin
                if ((BYPASS != 0) && w_wr_ok && (writeregsel == w_rsel[p])) begin
                    w_rdata[p] = writedata;
                    w_rbusy[p] = 1'b0;
                end else begin
                    w_rdata[p] = r_regs[w_rsel[p]];
                    w_rbusy[p] = r_busy[w_rsel[p]];
                end
            end
        end
    end

    assign read1data = w_rdata[0];
    assign read2data = w_rdata[1];
    assign read1busy = w_rbusy[0];
    assign read2busy = w_rbusy[1];
    assign err       = r_err;

    // Issue is applied after the write clear so a new producer keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[writeregsel] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[issueregsel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[writeregsel] <= writedata;
            end
            r_busy <= w_busy_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Drives two differently parametrised register files from shared inputs and checks them against a behavioural model.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1regsel, read2regsel, writeregsel, issueregsel;
    logic        write, issue;
    logic [15:0] writedata;

    logic [15:0] o_r1d [2];
    logic [15:0] o_r2d [2];
    logic        o_r1b [2];
    logic        o_r2b [2];
    logic        o_err [2];

    int checks = 0;
    int errors = 0;

    // Instance 0: 8 regs, bypass, no zero reg. Instance 1: 6 regs, no bypass, zero reg.
    int NR [2] = '{8, 6};
    bit BP [2] = '{1'b1, 1'b0};
    bit ZR [2] = '{1'b0, 1'b1};

    logic [15:0] m_regs [2][8];
    bit          m_busy [2][8];
    bit          m_err  [2];

    always #5 clk = ~clk;

    rf_scoreboard #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .BYPASS(1), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(o_r1d[0]), .read2data(o_r2d[0]),
        .read1busy(o_r1b[0]), .read2busy(o_r2b[0]),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .issue(issue), .issueregsel(issueregsel), .err(o_err[0])
    );

    rf_scoreboard #(.DATA_W(16), .NUM_REGS(6), .SEL_W(3), .BYPASS(0), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst),
        .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(o_r1d[1]), .read2data(o_r2d[1]),
        .read1busy(o_r1b[1]), .read2busy(o_r2b[1]),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .issue(issue), .issueregsel(issueregsel), .err(o_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wok(input int k, input int s);
        return (s < NR[k]) && !(ZR[k] && s == 0);
    endfunction

    // Expected read port value given stored model state and the current write inputs.
    task automatic m_read(input int k, input int s, output logic [15:0] d, output logic b);
        d = 16'h0;
        b = 1'b0;
        if (m_wok(k, s)) begin
            if (BP[k] && write && m_wok(k, int'(writeregsel)) && int'(writeregsel) == s) begin
                d = writedata;
            end else begin
                d = m_regs[k][s];
                b = m_busy[k][s];
            end
        end
    endtask

    task automatic chk_model();
        logic [15:0] d;
        logic        b;
        for (int k = 0; k < 2; k++) begin
            m_read(k, int'(read1regsel), d, b);
            chk($sformatf("u%0d.read1data", k), 32'(o_r1d[k]), 32'(d));
            chk($sformatf("u%0d.read1busy", k), 32'(o_r1b[k]), 32'(b));
            m_read(k, int'(read2regsel), d, b);
            chk($sformatf("u%0d.read2data", k), 32'(o_r2d[k]), 32'(d));
            chk($sformatf("u%0d.read2busy", k), 32'(o_r2b[k]), 32'(b));
            chk($sformatf("u%0d.err", k), 32'(o_err[k]), 32'(m_err[k]));
        end
    endtask

    task automatic tick();
        int  ws, is;
        bit  dbl;
        @(posedge clk);
        ws = int'(writeregsel);
        is = int'(issueregsel);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) begin
                    m_regs[k][r] = 16'h0;
                    m_busy[k][r] = 1'b0;
                end
                m_err[k] = 1'b0;
            end else begin
                dbl = issue && m_wok(k, is) && m_busy[k][is] && !(write && m_wok(k, ws) && ws == is);
                if ((write && ws >= NR[k]) || (issue && is >= NR[k]) || dbl) m_err[k] = 1'b1;
                if (write && m_wok(k, ws)) begin
                    m_regs[k][ws] = writedata;
                    m_busy[k][ws] = 1'b0;
                end
                if (issue && m_wok(k, is)) m_busy[k][is] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic setin(input bit r, input bit w, input int ws, input logic [15:0] wd,
                         input bit i, input int is, input int r1, input int r2);
        rst         = r;
        write       = w;
        writeregsel = 3'(ws);
        writedata   = wd;
        issue       = i;
        issueregsel = 3'(is);
        read1regsel = 3'(r1);
        read2regsel = 3'(r2);
        #1;
    endtask

    initial begin
        // Outputs are unknown before the first reset edge, so only check after it.
        setin(1, 1, 2, 16'h1111, 1, 2, 0, 0);
        tick();
        tick();

        for (int s = 0; s < 8; s++) begin
            setin(0, 0, 0, 16'h0, 0, 0, s, 7 - s);
            chk_model();
            chk("reset.read1data", 32'(o_r1d[0]), 32'h0);
            chk("reset.read2busy", 32'(o_r2b[0]), 32'h0);
            chk("reset.err", 32'(o_err[1]), 32'h0);
            tick();
        end

        setin(0, 1, 5, 16'hBEEF, 0, 0, 5, 0);
        chk_model();
        chk("bypass.same_cycle", 32'(o_r1d[0]), 32'hBEEF);
        chk("nobypass.same_cycle", 32'(o_r1d[1]), 32'h0);
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 5, 0);
        chk_model();
        chk("nobypass.next_cycle", 32'(o_r1d[1]), 32'hBEEF);
        tick();

        setin(0, 0, 0, 16'h0, 1, 3, 0, 3);
        chk_model();
        chk("issue.no_same_cycle_busy", 32'(o_r2b[0]), 32'h0);
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 0, 3);
        chk_model();
        chk("issue.busy_next", 32'(o_r2b[0]), 32'h1);
        tick();
        setin(0, 1, 3, 16'h1234, 0, 0, 0, 3);
        chk_model();
        chk("wb.bypass_busy", 32'(o_r2b[0]), 32'h0);
        chk("wb.bypass_data", 32'(o_r2d[0]), 32'h1234);
        chk("wb.nobypass_busy", 32'(o_r2b[1]), 32'h1);
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 0, 3);
        chk_model();
        chk("wb.busy_cleared", 32'(o_r2b[1]), 32'h0);
        tick();

        setin(0, 1, 3, 16'h5555, 1, 3, 0, 0);
        chk_model();
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 3, 0);
        chk_model();
        chk("newproducer.data", 32'(o_r1d[0]), 32'h5555);
        chk("newproducer.busy", 32'(o_r1b[0]), 32'h1);
        chk("newproducer.err", 32'(o_err[0]), 32'h0);
        setin(0, 0, 0, 16'h0, 1, 3, 3, 0);
        tick();
        for (int n = 0; n < 3; n++) begin
            setin(0, 0, 0, 16'h0, 0, 0, 3, 3);
            chk_model();
            chk("double_producer.err_sticky", 32'(o_err[0]), 32'h1);
            tick();
        end

        setin(1, 0, 0, 16'h0, 0, 0, 0, 0);
        tick();
        setin(0, 1, 7, 16'h7777, 0, 0, 7, 6);
        chk_model();
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 7, 6);
        chk_model();
        chk("oor.err_small", 32'(o_err[1]), 32'h1);
        chk("oor.err_full", 32'(o_err[0]), 32'h0);
        chk("oor.read_sel6_data", 32'(o_r2d[1]), 32'h0);
        chk("inrange.full_r7", 32'(o_r1d[0]), 32'h7777);
        tick();

        setin(1, 0, 0, 16'h0, 0, 0, 0, 0);
        tick();
        setin(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        chk_model();
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 0, 0);
        chk_model();
        chk("zero.data", 32'(o_r1d[1]), 32'h0);
        chk("zero.busy", 32'(o_r1b[1]), 32'h0);
        chk("zero.err", 32'(o_err[1]), 32'h0);
        chk("r0.normal_data", 32'(o_r1d[0]), 32'hFFFF);
        tick();
        setin(0, 1, 4, 16'h4444, 1, 2, 4, 2);
        tick();
        setin(1, 1, 4, 16'hAAAA, 1, 1, 4, 2);
        tick();
        setin(0, 0, 0, 16'h0, 0, 0, 4, 2);
        chk_model();
        chk("rst.clears_r4", 32'(o_r1d[0]), 32'h0);
        chk("rst.clears_busy", 32'(o_r2b[0]), 32'h0);
        tick();

        for (int n = 0; n < 500; n++) begin
            setin($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            chk_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
